// File: rtl/branch_predictor_bht_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht_pkg
// Shared types and helpers for the branch history table and the ECR side that
// produces its training pulses.
//   bp_update_t   : {en, pc, actual_taken} resolved-branch training record
//   BP_CTR_*      : counter values used when a new entry is allocated
//   bp_ctr_next() : 2-bit saturating counter step toward the actual outcome
// ---------------------------------------------------------------------------
package branch_predictor_bht_pkg;

    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic        actual_taken;
    } bp_update_t;

    localparam logic [1:0] BP_CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] BP_CTR_WEAK_T  = 2'b10;

    // Move one step toward the resolved direction; 2'b11 and 2'b00 stick.
    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] w_next;
        if (taken) begin
            w_next = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end else begin
            w_next = (ctr == 2'b00) ? ctr : ctr - 2'b01;
        end
        return w_next;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter32.sv
// ---------------------------------------------------------------------------
// bp_sat_counter32
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous reset, active low (clears the count)
//   i_inc   : count one event this cycle
//   o_count : current count
// ---------------------------------------------------------------------------
module bp_sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
// Tagged 2-bit saturating-counter branch history table. Trains on one pulse
// per resolved branch and answers issue-stage direction lookups
// combinationally from registered state.
// Ports:
//   clk                : clock
//   rst_n              : asynchronous reset, active low
//   i_lookup_pc        : PC of the branch being issued
//   o_pred_hit         : lookup PC matches a valid entry
//   o_pred_taken       : predicted direction (0 on a miss)
//   i_bp_update        : {en, pc, actual_taken} training pulse
//   i_clear_all        : synchronous invalidate of the whole table
//   o_stat_updates     : accepted updates (saturating)
//   o_stat_mispredicts : accepted updates whose prior prediction was wrong
// ---------------------------------------------------------------------------
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int NUM_ENTRIES = 64,
    parameter int TAG_WIDTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_lookup_pc,
    output logic        o_pred_hit,
    output logic        o_pred_taken,
    input  bp_update_t  i_bp_update,
    input  logic        i_clear_all,
    output logic [31:0] o_stat_updates,
    output logic [31:0] o_stat_mispredicts
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 1 + TAG_WIDTH;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [TAG_WIDTH-1:0]   r_tag [NUM_ENTRIES];
    logic [1:0]             r_ctr [NUM_ENTRIES];

    logic [IDX_W-1:0]     w_lk_idx;
    logic [TAG_WIDTH-1:0] w_lk_tag;
    logic                 w_lk_hit;
    logic [IDX_W-1:0]     w_up_idx;
    logic [TAG_WIDTH-1:0] w_up_tag;
    logic                 w_up_hit;
    logic                 w_up_pred;
    logic                 w_accept;
    logic                 w_mispredict;
    logic                 w_unused_pc_bits;

    assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
    assign w_lk_tag = i_lookup_pc[TAG_HI:TAG_LO];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign o_pred_hit   = w_lk_hit;
    assign o_pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];

    assign w_up_idx     = i_bp_update.pc[IDX_W+1:2];
    assign w_up_tag     = i_bp_update.pc[TAG_HI:TAG_LO];
    assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // Prediction the table would have given this branch before training.
    assign w_up_pred    = w_up_hit && r_ctr[w_up_idx][1];
    // clear_all wins over a concurrent update; the update is neither applied nor counted.
    assign w_accept     = i_bp_update.en && !i_clear_all;
    assign w_mispredict = w_accept && (w_up_pred != i_bp_update.actual_taken);

    assign w_unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[31:TAG_HI+1],
                                i_bp_update.pc[1:0], i_bp_update.pc[31:TAG_HI+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_ctr[i] <= BP_CTR_WEAK_NT;
            end
        end else if (i_clear_all) begin
            r_valid <= '0;
        end else if (i_bp_update.en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= bp_ctr_next(r_ctr[w_up_idx], i_bp_update.actual_taken);
            end else begin
                // Miss allocates (or retags an aliasing entry) at the weak state of the outcome.
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_ctr[w_up_idx]   <= i_bp_update.actual_taken ? BP_CTR_WEAK_T : BP_CTR_WEAK_NT;
            end
        end
    end

    bp_sat_counter32 u_stat_updates (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_accept),
        .o_count (o_stat_updates)
    );

    bp_sat_counter32 u_stat_mispredicts (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_mispredict),
        .o_count (o_stat_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
// Table-driven check of the branch history table: each row drives one cycle of
// inputs and holds the values the outputs must show before that cycle's edge.
// Expected rows are queued when driven and popped when the outputs are sampled.
// Hand-written sequences cover stat saturation and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;
    import branch_predictor_bht_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] lookupPc;
    logic        predHit;
    logic        predTaken;
    bp_update_t  bpUpdate;
    logic        clearAll;
    logic [31:0] statUpdates;
    logic [31:0] statMispredicts;

    int total;
    int bad;

    typedef struct {
        logic        updEn;
        logic [31:0] updPc;
        logic        updTaken;
        logic        clr;
        logic [31:0] lkPc;
        logic        expHit;
        logic        expTaken;
        logic [31:0] expUpd;
        logic [31:0] expMisp;
    } vec_t;

    typedef struct {
        logic        expHit;
        logic        expTaken;
        logic [31:0] expUpd;
        logic [31:0] expMisp;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];

    branch_predictor_bht #(.NUM_ENTRIES(64), .TAG_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_lookup_pc        (lookupPc),
        .o_pred_hit         (predHit),
        .o_pred_taken       (predTaken),
        .i_bp_update        (bpUpdate),
        .i_clear_all        (clearAll),
        .o_stat_updates     (statUpdates),
        .o_stat_mispredicts (statMispredicts)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    // Drive one row at the falling edge and queue the values expected before the next rising edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        bpUpdate.en           = v.updEn;
        bpUpdate.pc           = v.updPc;
        bpUpdate.actual_taken = v.updTaken;
        clearAll              = v.clr;
        lookupPc              = v.lkPc;
        e.expHit   = v.expHit;
        e.expTaken = v.expTaken;
        e.expUpd   = v.expUpd;
        e.expMisp  = v.expMisp;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        #1;
        if (scoreboard.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard: act=empty req=entry", tag);
        end else begin
            e = scoreboard.pop_front();
            check32({tag, " hit"},   {31'd0, predHit},   {31'd0, e.expHit});
            check32({tag, " taken"}, {31'd0, predTaken}, {31'd0, e.expTaken});
            check32({tag, " upd"},   statUpdates,        e.expUpd);
            check32({tag, " misp"},  statMispredicts,    e.expMisp);
        end
    endtask

    task automatic addVec(input logic en, input logic [31:0] pc, input logic tk, input logic clr,
                          input logic [31:0] lk, input logic h, input logic t,
                          input logic [31:0] u, input logic [31:0] m);
        vec_t v;
        v.updEn = en; v.updPc = pc; v.updTaken = tk; v.clr = clr; v.lkPc = lk;
        v.expHit = h; v.expTaken = t; v.expUpd = u; v.expMisp = m;
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        bpUpdate = '0;
        clearAll = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n    = 1'b0;
        lookupPc = 32'h0000_1000;
        bpUpdate = '0;
        clearAll = 1'b0;

        // 0x1000 and its alias 0x1100 share index 0 (tags 0x10 / 0x11); 0x1004 is index 1.
        //     en  upd pc        tk  clr lookup        hit tk  upd    misp
        addVec(0, 32'h0,         0,  0,  32'h0000_1000, 0, 0, 32'd0, 32'd0);
        addVec(1, 32'h0000_1000, 1,  0,  32'h0000_1000, 0, 0, 32'd0, 32'd0);
        addVec(0, 32'h0,         0,  0,  32'h0000_1000, 1, 1, 32'd1, 32'd1);
        addVec(1, 32'h0000_1000, 1,  0,  32'h0000_1000, 1, 1, 32'd1, 32'd1);
        addVec(1, 32'h0000_1000, 1,  0,  32'h0000_1000, 1, 1, 32'd2, 32'd1);
        addVec(1, 32'h0000_1000, 1,  0,  32'h0000_1000, 1, 1, 32'd3, 32'd1);
        addVec(1, 32'h0000_1000, 0,  0,  32'h0000_1000, 1, 1, 32'd4, 32'd1);
        addVec(1, 32'h0000_1000, 0,  0,  32'h0000_1000, 1, 1, 32'd5, 32'd2);
        addVec(0, 32'h0,         0,  0,  32'h0000_1000, 1, 0, 32'd6, 32'd3);
        addVec(1, 32'h0000_1000, 1,  0,  32'h0000_1000, 1, 0, 32'd6, 32'd3);
        addVec(1, 32'h0000_1100, 0,  0,  32'h0000_1000, 1, 1, 32'd7, 32'd4);
        addVec(0, 32'h0,         0,  0,  32'h0000_1000, 0, 0, 32'd8, 32'd4);
        addVec(0, 32'h0,         0,  0,  32'h0000_1100, 1, 0, 32'd8, 32'd4);
        addVec(1, 32'h0000_1004, 1,  0,  32'h0000_1004, 0, 0, 32'd8, 32'd4);
        addVec(0, 32'h0,         0,  0,  32'h0000_1004, 1, 1, 32'd9, 32'd5);
        addVec(1, 32'h0000_1004, 0,  1,  32'h0000_1004, 1, 1, 32'd9, 32'd5);
        addVec(0, 32'h0,         0,  0,  32'h0000_1004, 0, 0, 32'd9, 32'd5);
        addVec(0, 32'h0000_1100, 1,  0,  32'h0000_1100, 0, 0, 32'd9, 32'd5);
        addVec(0, 32'h0,         0,  0,  32'h0000_1100, 0, 0, 32'd9, 32'd5);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i));
        end
        @(negedge clk);
        idleInputs();

        // Asynchronous reset mid-stream: train 0x2000, then drop rst_n between edges.
        @(negedge clk);
        bpUpdate.en = 1'b1; bpUpdate.pc = 32'h0000_2000; bpUpdate.actual_taken = 1'b1;
        @(negedge clk);
        idleInputs();
        lookupPc = 32'h0000_2000;
        #1;
        check32("pre-reset hit", {31'd0, predHit}, 32'd1);
        check32("pre-reset upd", statUpdates, 32'd10);
        #1;
        rst_n = 1'b0;
        #1;
        check32("async reset hit",   {31'd0, predHit},   32'd0);
        check32("async reset taken", {31'd0, predTaken}, 32'd0);
        check32("async reset upd",   statUpdates,        32'd0);
        check32("async reset misp",  statMispredicts,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stat saturation: preload the update counter near the top, then keep updating.
        @(negedge clk);
        force dut.u_stat_updates.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stat_updates.r_count;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bpUpdate.en = 1'b1; bpUpdate.pc = 32'h0000_3000; bpUpdate.actual_taken = 1'b1;
            @(posedge clk);
            #1;
            check32($sformatf("sat upd %0d", k), statUpdates, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        idleInputs();
        lookupPc = 32'h0000_3000;
        #1;
        check32("sat entry hit",   {31'd0, predHit},   32'd1);
        check32("sat entry taken", {31'd0, predTaken}, 32'd1);
        check32("sat misp",        statMispredicts,    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
